// File: rtl/fixed_divider_pkg.sv
// ============================================================================
// Module   : fixed_divider_pkg
// Brief    : Shared state encoding and byte counts for the divider host.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fixed_divider_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_SET    = 3'd1,
    S_LOAD_UNLOCK = 3'd2,
    S_INIT        = 3'd3,
    S_WAIT        = 3'd4,
    S_READ_SEL    = 3'd5,
    S_READ_CAP    = 3'd6,
    S_DONE        = 3'd7
  } state_t;

  localparam int unsigned c_LOAD_BYTES = 8;
  localparam int unsigned c_READ_BYTES = 4;
  localparam int unsigned c_OPERAND_W  = 48;

  localparam logic [2:0] c_LAST_LOAD = 3'(c_LOAD_BYTES - 1);
  localparam logic [1:0] c_LAST_READ = 2'(c_READ_BYTES - 1);

endpackage

`default_nettype wire

// File: rtl/fixed_divider_byte_mux.sv
// ============================================================================
// Module   : fixed_divider_byte_mux
// Brief    : Selects operand byte k from the 48-bit operand, zero-padded to 8 bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fixed_divider_byte_mux
  import fixed_divider_pkg::*;
(
  input  logic [c_OPERAND_W-1:0] i_operand,
  input  logic [2:0]             i_index,
  output logic [7:0]             o_byte
);

  logic [7:0] w_bytes [c_LOAD_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < int'(c_LOAD_BYTES); gi++) begin : g_byte
      if (gi * 8 < int'(c_OPERAND_W)) begin : g_operand
        assign w_bytes[gi] = i_operand[gi*8 +: 8];
      end else begin : g_pad
        assign w_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign o_byte = w_bytes[i_index];

endmodule

`default_nettype wire

// File: rtl/fixed_divider_host.sv
// ============================================================================
// Module   : fixed_divider_host
// Brief    : Sequences one division through a byte-serial divider controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fixed_divider_host
  import fixed_divider_pkg::*;
#(
  parameter int unsigned CALC_WAIT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] num_a,
  input  logic [15:0] num_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [7:0]  inA,
  output logic        set,
  output logic        unlock,
  output logic [1:0]  select,
  output logic        init,
  input  logic [7:0]  out
);

  localparam logic [7:0] c_WAIT_LOAD = 8'(CALC_WAIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_num_a;
  logic [15:0] r_num_b;
  logic [2:0]  r_k;
  logic [1:0]  r_j;
  logic [7:0]  r_wait;
  logic [31:0] r_result;
  logic [7:0]  w_byte;

  fixed_divider_byte_mux u_byte_mux (
    .i_operand ({r_num_b, r_num_a}),
    .i_index   (r_k),
    .o_byte    (w_byte)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_num_a  <= '0;
      r_num_b  <= '0;
      r_k      <= '0;
      r_j      <= '0;
      r_wait   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_a <= num_a;
            r_num_b <= num_b;
            r_k     <= '0;
            r_j     <= '0;
          end
        end
        // k wraps 7 -> 0 together with the controller's own load counter
        S_LOAD_UNLOCK: r_k <= r_k + 3'd1;
        S_INIT:        r_wait <= c_WAIT_LOAD;
        S_WAIT: begin
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end
        end
        S_READ_CAP: begin
          r_result[{r_j, 3'b000} +: 8] <= out;
          r_j <= r_j + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    set          = 1'b0;
    unlock       = 1'b0;
    init         = 1'b0;
    select       = 2'd0;
    inA          = 8'h00;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = S_LOAD_SET;
        end
      end
      S_LOAD_SET: begin
        set          = 1'b1;
        inA          = w_byte;
        w_next_state = S_LOAD_UNLOCK;
      end
      S_LOAD_UNLOCK: begin
        unlock       = 1'b1;
        inA          = w_byte;
        w_next_state = (r_k == c_LAST_LOAD) ? S_INIT : S_LOAD_SET;
      end
      S_INIT: begin
        init         = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait == 8'd0) begin
          w_next_state = S_READ_SEL;
        end
      end
      S_READ_SEL: begin
        select       = r_j;
        w_next_state = S_READ_CAP;
      end
      S_READ_CAP: begin
        select       = r_j;
        w_next_state = (r_j == c_LAST_READ) ? S_DONE : S_READ_SEL;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_fixed_divider_host.sv
// ============================================================================
// Module   : tb_fixed_divider_host
// Brief    : Directed and random checks of the divider host against a timeline model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fixed_divider_host;

  localparam int W   = 40;
  localparam int LAT = 26 + W;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start;
  logic [31:0] num_a;
  logic [15:0] num_b;
  logic        busy, done, set, unlock, init;
  logic [31:0] result;
  logic [7:0]  inA;
  logic [1:0]  select;
  logic [7:0]  out_b;

  int n_vec  = 0;
  int n_fail = 0;

  fixed_divider_host #(.CALC_WAIT(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .num_a  (num_a),
    .num_b  (num_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .inA    (inA),
    .set    (set),
    .unlock (unlock),
    .select (select),
    .init   (init),
    .out    (out_b)
  );

  always #5 clock = ~clock;

  // Controller/divider model: bytes stored at a 3-bit load counter, quotient on init.
  logic [7:0]  m_regs [8];
  logic [2:0]  m_cnt = '0;
  logic [31:0] m_q   = '0;

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 32'hDEADBEEF : a / {16'h0, b};
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= '0;
    end else begin
      if (set) begin
        m_regs[m_cnt] <= inA;
        m_cnt <= m_cnt + 3'd1;
      end
      if (init) begin
        m_q <= quot({m_regs[3], m_regs[2], m_regs[1], m_regs[0]}, {m_regs[5], m_regs[4]});
      end
    end
  end

  assign out_b = m_q[{select, 3'b000} +: 8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {busy,done,set,unlock,init,select,inA} in cycle c after the accepting edge.
  function automatic logic [14:0] timeline(input int c, input logic [47:0] opnd);
    logic [63:0] padded;
    logic        busy_e, done_e, set_e, unlock_e, init_e;
    logic [1:0]  sel_e;
    logic [7:0]  ina_e;
    padded   = {16'h0, opnd};
    busy_e   = (c >= 1 && c <= LAT);
    done_e   = (c == LAT);
    set_e    = (c >= 1 && c <= 16 && (c % 2) == 1);
    unlock_e = (c >= 2 && c <= 16 && (c % 2) == 0);
    init_e   = (c == 17);
    sel_e    = (c >= 18 + W && c <= 25 + W) ? 2'((c - (18 + W)) / 2) : 2'd0;
    ina_e    = (c >= 1 && c <= 16) ? padded[((c - 1) / 2) * 8 +: 8] : 8'h00;
    return {busy_e, done_e, set_e, unlock_e, init_e, sel_e, ina_e};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input bit pre_started,
                        input bit keep_start, input bit pulse_mid, input string tag);
    logic [31:0] exp_q;
    exp_q = quot(a, b);
    if (!pre_started) begin
      @(negedge clock);
      start = 1'b1;
    end
    num_a = a;
    num_b = b;
    check({tag, ":idle"}, {60'd0, busy, m_cnt}, 64'd0);
    @(posedge clock);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clock);
      check($sformatf("%s:cyc%0d", tag, c),
            {49'd0, busy, done, set, unlock, init, select, inA}, {49'd0, timeline(c, {b, a})});
      if (c == LAT)     check({tag, ":result"}, {32'd0, result}, {32'd0, exp_q});
      if (c == LAT + 1) check({tag, ":hold"},   {32'd0, result}, {32'd0, exp_q});
      if (c == 1 && !keep_start) start = 1'b0;
      if (pulse_mid && (c == 5 || c == 30)) begin
        start = 1'b1;
        num_a = $urandom;
        num_b = 16'($urandom);
      end
      if (pulse_mid && (c == 6 || c == 31)) start = 1'b0;
    end
  endtask

  initial begin
    int  nsets;
    bit  saw;
    start   = 1'b0;
    num_a   = '0;
    num_b   = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset", {17'd0, busy, done, set, unlock, init, select, inA, result}, 64'd0);
    reset_n = 1'b1;

    run_op(32'd100, 16'd7, 1'b0, 1'b0, 1'b0, "div100_7");
    run_op(32'hFFFFFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "allones");
    run_op(32'd1000, 16'd10, 1'b0, 1'b1, 1'b0, "b2b_1");
    run_op(32'd81, 16'd9, 1'b1, 1'b0, 1'b0, "b2b_2");
    run_op(32'd123456789, 16'd321, 1'b0, 1'b0, 1'b1, "pulse");
    run_op(32'h12345678, 16'd0, 1'b0, 1'b0, 1'b0, "div0");
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, 16'($urandom_range(1, 65535)), 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset asserted during the fourth LOAD_SET
    @(negedge clock);
    start = 1'b1;
    num_a = 32'hCAFEF00D;
    num_b = 16'h1234;
    @(posedge clock);
    nsets = 0;
    for (int c = 1; c <= 20 && nsets < 4; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (set) nsets++;
    end
    check("rst_reach", 64'(nsets), 64'd4);
    #1 reset_n = 1'b0;
    #1 check("rst_async", {17'd0, busy, done, set, unlock, init, select, inA, result}, 64'd0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) saw = 1'b1;
    end
    check("rst_no_done", {63'd0, saw}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_idle", {62'd0, busy, done}, 64'd0);

    run_op(32'd50000, 16'd7, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fixed_divider_host.md
FIXED_DIVIDER_HOST -- requirements
Module: fixed_divider_host

Interface
REQ-001 SHALL have parameter CALC_WAIT, default 40, meaning cycles waited after the init pulse before result readback (range 1..255).
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to run one division; accepted only in IDLE.
REQ-005 SHALL have port num_a, input, 32, dividend; sampled on the accepting edge.
REQ-006 SHALL have port num_b, input, 16, divisor; sampled on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-009 SHALL have port result, output, 32, assembled quotient; holds until the next done.
REQ-010 SHALL have port inA, output, 8, operand byte driven to the byte-serial divider controller.
REQ-011 SHALL have ports set and unlock, outputs, 1 each, load strobe and lock-release strobe to the controller.
REQ-012 SHALL have port select, output, 2, result byte index driven to the controller.
REQ-013 SHALL have port init, output, 1, one-cycle divider start pulse.
REQ-014 SHALL have port out, input, 8, result byte returned by the controller for the current select.

Function
REQ-015 SHALL implement states IDLE, LOAD_SET, LOAD_UNLOCK, INIT, WAIT, READ_SEL, READ_CAP, DONE.
REQ-016 IDLE with start=1 SHALL latch num_a and num_b, clear the byte index k, and go to LOAD_SET.
REQ-017 LOAD_SET SHALL drive inA = byte k of {16'h0, num_b, num_a} (k=0 is num_a[7:0]), set=1, unlock=0, then go to LOAD_UNLOCK.
REQ-018 LOAD_UNLOCK SHALL drive set=0, unlock=1, hold inA, and increment k; it returns to LOAD_SET while k<7, else goes to INIT.
REQ-019 Exactly 8 set pulses SHALL be issued per operation, bytes 6 and 7 being 8'h00, so the controller's 3-bit load counter wraps back to 0.
REQ-020 INIT SHALL assert init for exactly one cycle, then go to WAIT with the wait counter loaded to CALC_WAIT-1.
REQ-021 WAIT SHALL decrement the wait counter each cycle and go to READ_SEL on the cycle it reads 0.
REQ-022 READ_SEL SHALL drive select=j; READ_CAP SHALL keep select=j and capture out into result byte j at the end of that cycle; after j=3 it goes to DONE.
REQ-023 DONE SHALL pulse done for one cycle with result updated, then return to IDLE.
REQ-024 Latency SHALL be fixed: done is high exactly 26+CALC_WAIT cycles after the edge that accepts start (66 at default).
REQ-025 start SHALL be ignored while busy=1; start held high in IDLE after DONE SHALL begin a new operation.
REQ-026 set and unlock SHALL never be high in the same cycle; inA, select, and init SHALL be 0 in every state where they are not specified above.
REQ-027 A divisor of 0 SHALL be passed through unchanged; result is whatever the controller returns.

Reset
REQ-028 reset_n low SHALL immediately force IDLE and set busy, done, set, unlock, init, inA, select, result, k, j, and the wait counter to 0, including mid-operation.
REQ-029 After a mid-load reset, the host SHALL NOT attempt to resynchronise the controller's load counter; system-level reset of the controller is the integrator's responsibility.

Structure
REQ-030 State encodings, the load byte count (8), and the readback byte count (4) SHALL live in a shared package fixed_divider_pkg.
REQ-031 A sub-module fixed_divider_byte_mux, selecting operand byte k from the 48-bit operand plus zero pad, is natural; the FSM, counters, and result register SHALL stay in fixed_divider_host.

Verification
REQ-032 num_a=100, num_b=7, paired with a behavioural controller/divider model: inA sequence 64,00,00,00,07,00,00,00 on the set cycles -> done at cycle 66, result=32'h0000000E.
REQ-033 num_a=32'hFFFFFFFF, num_b=16'h0001: -> result=32'hFFFFFFFF; select steps 0,1,2,3 with 2 cycles each.
REQ-034 Two back-to-back operations (1000/10, then 81/9): -> results 100 and 9; the model's load counter is 0 at the start of each load.
REQ-035 start pulsed at cycles 5 and 30 of an active operation: -> no state change, single done, busy continuous.
REQ-036 reset_n low during the 4th LOAD_SET: -> all outputs 0 asynchronously, state IDLE, no done pulse.
REQ-037 num_b=0 with a model returning 32'hDEADBEEF: -> result=32'hDEADBEEF, latency unchanged.
